lives_manager: RTL and testbench
================================

// Module: lives_manager
// PURPOSE
//  Tracks the player's remaining lives and produces the gameOver request that
//  the game-over message FSM consumes. Takes ship-collision and bonus-life
//  events and grants a frame-counted invulnerability window after each hit.
//  When lives reach zero it raises a sticky gameOver level. Sits between the
//  collision/bonus logic and the messages block.
// PARAMETERS
//  INIT_LIVES     3    lives loaded at reset
//  MAX_LIVES      5    saturation ceiling for lives (>= INIT_LIVES)
//  LIVES_W        3    width of lives counter (holds MAX_LIVES)
//  INVULN_FRAMES  60   frames of invulnerability after a non-fatal hit (>= 1)
//  FRAME_W        8    width of invulnerability frame counter
// PORTS
//  clk           in   1        system clock
//  resetN        in   1        asynchronous active-low reset
//  startOfFrame  in   1        one-cycle pulse per video frame
//  collision     in   1        ship hit; level, sampled every clk
//  extraLife     in   1        one-cycle bonus-life pulse
//  lives         out  LIVES_W  current lives count, registered
//  invulnerable  out  1        high while hits are ignored, registered
//  hitPulse      out  1        one-cycle pulse per accepted non-fatal hit
//  gameOver      out  1        sticky high once lives hit zero
// BEHAVIOUR
//  Reset (async, resetN=0): state=S_ALIVE, lives=INIT_LIVES, timer=0,
//   invulnerable=0, hitPulse=0, gameOver=0. Applies mid-operation from any state.
//  All outputs registered: each output changes on the clk edge after the input
//   event that causes it (1-cycle latency).
//  States: S_ALIVE, S_INVULN, S_DEAD.
//  S_ALIVE:
//   - collision=1, extraLife=0, lives==1 -> lives=0, gameOver=1, go S_DEAD.
//     hitPulse stays 0 (fatal hit).
//   - collision=1, otherwise -> lives = lives-1+extraLife, clamped to MAX_LIVES.
//     hitPulse=1 for one cycle. timer=INVULN_FRAMES. go S_INVULN.
//   - collision=0, extraLife=1 -> lives=min(lives+1, MAX_LIVES).
//  S_INVULN: invulnerable=1. collision is ignored.
//   - extraLife still increments lives with saturation.
//   - On startOfFrame, timer decrements.
//   - startOfFrame with timer==1 -> timer=0, invulnerable=0, go S_ALIVE.
//   - If startOfFrame arrives in the same cycle the timer is loaded, the load
//     wins. The window is INVULN_FRAMES full frame pulses after entry.
//  S_DEAD: gameOver=1, invulnerable=0, lives=0. Every input is ignored.
//   Only resetN leaves this state.
//  A collision held high past the end of the window is taken as a new hit on
//   the first S_ALIVE cycle.
//  Arithmetic is unsigned. lives never wraps below 0 or above MAX_LIVES.
// TESTING
//  1. Reset, then one collision pulse -> next cycle lives=2, hitPulse=1 for one
//     cycle, invulnerable=1.
//  2. With INVULN_FRAMES=3, hit, then collision held high -> lives stays 2 for
//     3 startOfFrame pulses; invulnerable drops after the 3rd; next cycle
//     lives=1.
//  3. Three hits spaced past each window -> after the 3rd, gameOver=1,
//     lives=0, hitPulse=0; further collision/extraLife have no effect until
//     resetN.
//  4. At lives=1, collision and extraLife in the same cycle -> lives=1,
//     hitPulse=1, S_INVULN, gameOver=0.
//  5. extraLife x4 from lives=3 with MAX_LIVES=5 -> lives=5 (saturated);
//     then hit+extraLife together -> lives stays 5.
//  6. Assert resetN=0 during S_INVULN and during S_DEAD -> all outputs go to
//     their reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/lives_manager.sv
// lives_manager: tracks the player's remaining lives.
// A non-fatal ship hit costs one life, pulses hitPulse and opens an
// invulnerability window that lasts a fixed number of video frames.
// Losing the last life raises a sticky gameOver level, which only
// resetN clears. A bonus life adds one life, saturating at MAX_LIVES.
// All outputs come straight from registers.
module lives_manager #(
    parameter int INIT_LIVES    = 3,
    parameter int MAX_LIVES     = 5,
    parameter int LIVES_W       = 3,
    parameter int INVULN_FRAMES = 60,
    parameter int FRAME_W       = 8
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               collision,
    input  logic               extraLife,
    output logic [LIVES_W-1:0] lives,
    output logic               invulnerable,
    output logic               hitPulse,
    output logic               gameOver
);

    typedef enum logic [1:0] {
        S_ALIVE  = 2'd0,
        S_INVULN = 2'd1,
        S_DEAD   = 2'd2
    } state_t;

    localparam logic [LIVES_W-1:0] L_MAX  = LIVES_W'(MAX_LIVES);
    localparam logic [LIVES_W-1:0] L_INIT = LIVES_W'(INIT_LIVES);
    localparam logic [LIVES_W-1:0] L_ONE  = LIVES_W'(1);
    localparam logic [LIVES_W-1:0] L_ZERO = LIVES_W'(0);
    localparam logic [FRAME_W-1:0] T_LOAD = FRAME_W'(INVULN_FRAMES);
    localparam logic [FRAME_W-1:0] T_ONE  = FRAME_W'(1);
    localparam logic [FRAME_W-1:0] T_ZERO = FRAME_W'(0);

    state_t             r_state;
    logic [LIVES_W-1:0] r_lives;
    logic [FRAME_W-1:0] r_timer;
    logic               r_invuln;
    logic               r_hit;
    logic               r_gameover;

    logic               w_fatal;
    logic               w_window_end;

    // One extra life, never beyond the ceiling.
    function automatic logic [LIVES_W-1:0] f_inc_sat(input logic [LIVES_W-1:0] l);
        if (l >= L_MAX) begin
            return L_MAX;
        end else begin
            return l + L_ONE;
        end
    endfunction

    // Lives after an accepted hit: minus one, plus a same-cycle bonus,
    // clamped to [0, MAX_LIVES].
    function automatic logic [LIVES_W-1:0] f_hit_lives(input logic [LIVES_W-1:0] l,
                                                       input logic              xl);
        if (xl) begin
            return (l >= L_MAX) ? L_MAX : l;
        end else begin
            return (l == L_ZERO) ? L_ZERO : l - L_ONE;
        end
    endfunction

    // A hit on the last life with no bonus to offset it ends the game.
    assign w_fatal      = collision && !extraLife && (r_lives <= L_ONE);
    // The frame pulse that consumes the final frame of the window.
    assign w_window_end = startOfFrame && (r_timer <= T_ONE);

    // Lives/invulnerability state machine with registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state    <= S_ALIVE;
            r_lives    <= L_INIT;
            r_timer    <= T_ZERO;
            r_invuln   <= 1'b0;
            r_hit      <= 1'b0;
            r_gameover <= 1'b0;
        end else begin
            case (r_state)
                S_ALIVE: begin
                    if (collision && w_fatal) begin
                        r_lives    <= L_ZERO;
                        r_gameover <= 1'b1;
                        r_invuln   <= 1'b0;
                        r_hit      <= 1'b0;
                        r_state    <= S_DEAD;
                    end else if (collision) begin
                        // Loading the timer here takes precedence over any
                        // frame pulse in this same cycle.
                        r_lives  <= f_hit_lives(r_lives, extraLife);
                        r_timer  <= T_LOAD;
                        r_invuln <= 1'b1;
                        r_hit    <= 1'b1;
                        r_state  <= S_INVULN;
                    end else if (extraLife) begin
                        r_lives <= f_inc_sat(r_lives);
                        r_hit   <= 1'b0;
                    end else begin
                        r_hit <= 1'b0;
                    end
                end
                S_INVULN: begin
                    r_hit <= 1'b0;
                    if (extraLife) begin
                        r_lives <= f_inc_sat(r_lives);
                    end else begin
                        r_lives <= r_lives;
                    end
                    if (w_window_end) begin
                        r_timer  <= T_ZERO;
                        r_invuln <= 1'b0;
                        r_state  <= S_ALIVE;
                    end else if (startOfFrame) begin
                        r_timer  <= r_timer - T_ONE;
                        r_invuln <= 1'b1;
                    end else begin
                        r_invuln <= 1'b1;
                    end
                end
                S_DEAD: begin
                    r_lives    <= L_ZERO;
                    r_gameover <= 1'b1;
                    r_invuln   <= 1'b0;
                    r_hit      <= 1'b0;
                    r_timer    <= T_ZERO;
                end
                default: begin
                    // An illegal state encoding is treated as game over.
                    r_state    <= S_DEAD;
                    r_lives    <= L_ZERO;
                    r_gameover <= 1'b1;
                    r_invuln   <= 1'b0;
                    r_hit      <= 1'b0;
                    r_timer    <= T_ZERO;
                end
            endcase
        end
    end

    assign lives        = r_lives;
    assign invulnerable = r_invuln;
    assign hitPulse     = r_hit;
    assign gameOver     = r_gameover;

endmodule

// File: tb/tb_lives_manager.sv
// tb_lives_manager: directed vectors for lives_manager with a 3-frame
// invulnerability window. The driver pushes hand-computed expectations
// into a queue; an independent monitor pops and compares them.
module tb_lives_manager;

    localparam int LW = 3;

    logic          clk;
    logic          resetN;
    logic          startOfFrame;
    logic          collision;
    logic          extraLife;
    logic [LW-1:0] lives;
    logic          invulnerable;
    logic          hitPulse;
    logic          gameOver;

    typedef struct {
        string         name;
        logic [LW-1:0] lives;
        logic          inv;
        logic          hit;
        logic          go;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    event async_ev;

    lives_manager #(
        .INIT_LIVES   (3),
        .MAX_LIVES    (5),
        .LIVES_W      (LW),
        .INVULN_FRAMES(3),
        .FRAME_W      (8)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .collision   (collision),
        .extraLife   (extraLife),
        .lives       (lives),
        .invulnerable(invulnerable),
        .hitPulse    (hitPulse),
        .gameOver    (gameOver)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic sof, input logic col, input logic xl,
                        input logic [LW-1:0] e_l, input logic e_i,
                        input logic e_h, input logic e_g, input string nm);
        exp_t e;
        @(negedge clk);
        startOfFrame = sof;
        collision    = col;
        extraLife    = xl;
        e.name = nm; e.lives = e_l; e.inv = e_i; e.hit = e_h; e.go = e_g;
        exp_q.push_back(e);
    endtask

    // Pull resetN low between clock edges and expect reset values at once.
    task automatic async_reset(input string nm);
        exp_t e;
        @(posedge clk);
        #3;
        startOfFrame = 1'b0;
        collision    = 1'b0;
        extraLife    = 1'b0;
        resetN       = 1'b0;
        e.name = nm; e.lives = 3'd3; e.inv = 1'b0; e.hit = 1'b0; e.go = 1'b0;
        exp_q.push_back(e);
        ->async_ev;
        @(negedge clk);
        resetN = 1'b1;
    endtask

    // Monitor: compare DUT outputs with the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or async_ev);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (lives !== e.lives || invulnerable !== e.inv ||
                    hitPulse !== e.hit || gameOver !== e.go) begin
                    n_miss++;
                    $display("FAIL %s: got lives=%0d inv=%b hit=%b go=%b, want lives=%0d inv=%b hit=%b go=%b",
                             e.name, lives, invulnerable, hitPulse, gameOver,
                             e.lives, e.inv, e.hit, e.go);
                end
            end
        end
    end

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        collision    = 1'b0;
        extraLife    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;

        //    sof   col   xl    lives inv   hit   go
        step(1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, "reset_idle");
        // single hit
        step(1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, "t1_hit");
        step(1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, "t1_pulse_drop");
        // collision held through the window, then re-taken
        step(1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, "t2_sof1");
        step(1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, "t2_no_sof");
        step(1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, "t2_sof2");
        step(1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, "t2_sof3_end");
        step(1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, "t2_rehit");
        step(1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, "w_sof1");
        step(1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, "w_sof2");
        step(1'b1, 1'b0, 1'b0, 3'd1, 0,    1'b0, 1'b0, "w_sof3_end");
        // hit + bonus at one life, frame pulse in the load cycle
        step(1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0, "t4_hit_xl_load");
        step(1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, "t4_sof1");
        step(1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, "t4_sof2");
        step(1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, "t4_sof3_end");
        // fatal hit, then dead state ignores everything
        step(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, "t3_fatal");
        step(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, "t3_dead_all");
        step(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, "t3_dead_xl");
        step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, "t3_dead_idle");
        async_reset("t6_reset_in_dead");
        step(1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, "t6_after_dead");
        // bonus saturation
        step(1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, "t5_xl1");
        step(1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, "t5_xl2");
        step(1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, "t5_xl3_sat");
        step(1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, "t5_xl4_sat");
        step(1'b0, 1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, "t5_hit_xl_sat");
        step(1'b0, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, "t5_invuln_ignore");
        async_reset("t6_reset_in_invuln");
        step(1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, "t6_after_invuln");
        // bonus accepted during the window
        step(1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, "x_hit");
        step(1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, "x_xl_in_invuln");
        step(1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, "x_idle");

        @(negedge clk);
        startOfFrame = 1'b0;
        collision    = 1'b0;
        extraLife    = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
